// File: rtl/keypad_scan_reader_pkg.sv
// Shared constants for the keypad scanner: bus addresses, event-code field
// positions and read-word bit positions.
package keypad_scan_reader_pkg;

  localparam logic [15:0] KEYPAD_DEV_ADDR = 16'h0041;

  localparam int CODE_W    = 9;
  localparam int PRESS_BIT = 8;
  localparam int ROW_LSB   = 4;
  localparam int COL_LSB   = 0;
  localparam int VALID_BIT = 15;
  localparam int OVF_BIT   = 14;

  typedef enum logic [1:0] {
    BUS_NONE,
    BUS_POP,
    BUS_STATUS
  } bus_op_e;

  function automatic logic [CODE_W-1:0] make_event(input logic press,
                                                   input logic [3:0] row,
                                                   input logic [3:0] col);
    logic [CODE_W-1:0] code;
    code                    = '0;
    code[PRESS_BIT]         = press;
    code[ROW_LSB+3:ROW_LSB] = row;
    code[COL_LSB+3:COL_LSB] = col;
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_reader_fifo.sv
// Synchronous show-ahead FIFO for key events. A pop in the same cycle as a push
// frees a slot, so a full FIFO still accepts that push.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_pop, do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_reader.sv
// Matrix keypad scanner: one-cold column drive, synchronised row sense, per-key
// debounce, event FIFO and a pop/status read port on the DEVICE/DATA bus.
module keypad_scan_reader
  import keypad_scan_reader_pkg::*;
#(
  parameter int          ROWS       = 4,
  parameter int          COLS       = 4,
  parameter int          SCAN_DIV   = 15,
  parameter int          DEBOUNCE   = 3,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DEV_ADDR   = KEYPAD_DEV_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     DEVICE,
  input  logic            rd,
  output logic [15:0]     DATA_out,
  output logic [COLS-1:0] key_col_out,
  input  logic [ROWS-1:0] key_row_in,
  output logic            key_irq
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NKEYS = ROWS * COLS;
  localparam int KEY_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ROWS-1:0]     row_meta_reg, row_sync_reg;
  logic [SCAN_DIV-1:0] presc_reg;
  logic [COL_W-1:0]    col_idx_reg, snap_col_reg;
  logic [ROWS-1:0]     snap_reg;
  logic [ROW_W-1:0]    row_idx_reg;
  logic                sweep_on_reg;
  logic                tick;

  logic [NKEYS-1:0]    stable_reg;
  logic [1:0]          cnt_reg [NKEYS];
  logic [KEY_W-1:0]    key_idx;
  logic                sample, stable_cur, key_toggle;
  logic [1:0]          cnt_inc;

  logic [CODE_W-1:0]   fifo_dout;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic                ovf_reg, irq_reg;
  logic [15:0]         data_reg, pop_word, status_word;
  bus_op_e             bus_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= key_row_in;
      row_sync_reg <= row_meta_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
      assign key_col_out[gi] = (col_idx_reg != COL_W'(gi));
    end
  endgenerate

  assign tick = &presc_reg;

  // The tick snapshots the column's rows; the keys are then debounced one row
  // per clk so the FIFO sees at most one push per cycle (needs ROWS <= 2**SCAN_DIV).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      col_idx_reg  <= '0;
      snap_reg     <= '0;
      snap_col_reg <= '0;
      row_idx_reg  <= '0;
      sweep_on_reg <= 1'b0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
      if (tick) begin
        snap_reg     <= ~row_sync_reg;
        snap_col_reg <= col_idx_reg;
        row_idx_reg  <= '0;
        sweep_on_reg <= 1'b1;
        col_idx_reg  <= (col_idx_reg == COL_W'(COLS-1)) ? '0 : col_idx_reg + 1'b1;
      end else if (sweep_on_reg) begin
        row_idx_reg <= row_idx_reg + 1'b1;
        if (row_idx_reg == ROW_W'(ROWS-1)) sweep_on_reg <= 1'b0;
      end
    end
  end

  assign key_idx    = KEY_W'(int'(row_idx_reg) * COLS + int'(snap_col_reg));
  assign sample     = snap_reg[row_idx_reg];
  assign stable_cur = stable_reg[key_idx];
  assign cnt_inc    = cnt_reg[key_idx] + 2'd1;
  assign key_toggle = sweep_on_reg && (sample != stable_cur) && (cnt_inc == 2'(DEBOUNCE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_reg <= '0;
      for (int k = 0; k < NKEYS; k++) cnt_reg[k] <= 2'd0;
    end else if (sweep_on_reg) begin
      if (sample == stable_cur) begin
        cnt_reg[key_idx] <= 2'd0;
      end else if (key_toggle) begin
        stable_reg[key_idx] <= sample;
        cnt_reg[key_idx]    <= 2'd0;
      end else begin
        cnt_reg[key_idx] <= cnt_inc;
      end
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (key_toggle),
    .din   (make_event(sample, 4'(row_idx_reg), 4'(snap_col_reg))),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    bus_op = BUS_NONE;
    if (rd && DEVICE == DEV_ADDR)              bus_op = BUS_POP;
    else if (rd && DEVICE == DEV_ADDR + 16'd1) bus_op = BUS_STATUS;
  end

  assign fifo_pop = (bus_op == BUS_POP) && !fifo_empty;

  always_comb begin
    pop_word              = '0;
    pop_word[OVF_BIT]     = ovf_reg;
    if (!fifo_empty) begin
      pop_word[VALID_BIT]       = 1'b1;
      pop_word[CODE_W-1:0]      = fifo_dout;
    end
    status_word           = '0;
    status_word[15]       = ovf_reg;
    status_word[4:0]      = 5'(fifo_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      ovf_reg  <= 1'b0;
      irq_reg  <= 1'b0;
    end else begin
      irq_reg <= !fifo_empty;
      if (key_toggle && fifo_full && !fifo_pop) ovf_reg <= 1'b1;
      else if (bus_op == BUS_POP)                ovf_reg <= 1'b0;
      case (bus_op)
        BUS_POP:    data_reg <= pop_word;
        BUS_STATUS: data_reg <= status_word;
        default:    data_reg <= data_reg;
      endcase
    end
  end

  assign DATA_out = data_reg;
  assign key_irq  = irq_reg;

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Directed bench for keypad_scan_reader: a 4x4 key-matrix model feeds the rows,
// and each step checks bus reads, interrupt and column drive against fixed values.
module tb_keypad_scan_reader;

  localparam logic [15:0] POP_A  = 16'h0041;
  localparam logic [15:0] STAT_A = 16'h0042;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] DEVICE;
  logic        rd;
  logic [15:0] DATA_out;
  logic [3:0]  key_col_out;
  logic [3:0]  key_row_in;
  logic        key_irq;

  logic [15:0] keys;   // keys[r*4+c] = 1 while key (row r, col c) is held
  logic [15:0] rdata;
  int          vectors = 0;
  int          miscompares = 0;

  keypad_scan_reader #(
    .ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(2), .FIFO_DEPTH(4), .DEV_ADDR(16'h0041)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DEVICE(DEVICE), .rd(rd), .DATA_out(DATA_out),
    .key_col_out(key_col_out), .key_row_in(key_row_in), .key_irq(key_irq)
  );

  always #5 clk = ~clk;

  // A row reads low when any held key in that row sits on the driven column.
  always_comb begin
    key_row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col_out[c]) key_row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    DEVICE = addr;
    rd     = 1'b1;
    @(negedge clk);
    rd     = 1'b0;
    DEVICE = 16'h0000;
    data   = DATA_out;
  endtask

  task automatic wait_frames3;
    repeat (56) @(negedge clk);
  endtask

  // Returns at the first negedge after the column drive switches to target.
  task automatic wait_col_enter(input logic [3:0] target);
    logic [3:0] prev;
    bit         found;
    int         n;
    prev  = key_col_out;
    found = 1'b0;
    n     = 0;
    while (!found && n < 64) begin
      @(negedge clk);
      if (key_col_out == target && prev != target) found = 1'b1;
      prev = key_col_out;
      n++;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $error("FAIL col_timeout: observed=%h expected=%h", key_col_out, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    rd     = 1'b0;
    DEVICE = 16'h0000;
    keys   = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_col", {12'h000, key_col_out}, 16'h000E);
    check("reset_irq", {15'h0, key_irq}, 16'h0000);
    check("reset_data", DATA_out, 16'h0000);
    rst_n = 1'b1;

    // 1: reset mid-scan with an event queued and DATA_out non-zero
    keys[2*4+1] = 1'b1;
    wait_frames3();
    check("pre_reset_irq", {15'h0, key_irq}, 16'h0001);
    bus_read(STAT_A, rdata);
    check("pre_reset_status", rdata, 16'h0001);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_col", {12'h000, key_col_out}, 16'h000E);
    check("midreset_irq", {15'h0, key_irq}, 16'h0000);
    check("midreset_data", DATA_out, 16'h0000);
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(STAT_A, rdata);
    check("post_reset_status", rdata, 16'h0000);

    // 2: clean press of row2/col1
    keys[2*4+1] = 1'b1;
    wait_frames3();
    check("press_irq", {15'h0, key_irq}, 16'h0001);
    bus_read(POP_A, rdata);
    check("press_pop", rdata, 16'h8121);
    bus_read(POP_A, rdata);
    check("press_pop_empty", rdata, 16'h0000);
    @(negedge clk);
    check("press_irq_clear", {15'h0, key_irq}, 16'h0000);

    // 3: release of the same key
    keys[2*4+1] = 1'b0;
    wait_frames3();
    bus_read(POP_A, rdata);
    check("release_pop", rdata, 16'h8021);

    // 4: row0/col3 held across exactly one sample tick
    wait_col_enter(4'b0111);
    keys[0*4+3] = 1'b1;
    repeat (8) @(negedge clk);
    keys[0*4+3] = 1'b0;
    repeat (40) @(negedge clk);
    bus_read(STAT_A, rdata);
    check("bounce_status", rdata, 16'h0000);
    check("bounce_irq", {15'h0, key_irq}, 16'h0000);

    // 5: five presses with no reads; the fifth is dropped and sets ovf
    keys[2*4+1] = 1'b1; wait_frames3();
    keys[0*4+0] = 1'b1; wait_frames3();
    keys[1*4+2] = 1'b1; wait_frames3();
    keys[3*4+3] = 1'b1; wait_frames3();
    keys[1*4+0] = 1'b1; wait_frames3();
    bus_read(STAT_A, rdata);
    check("ovf_status", rdata, 16'h8004);
    bus_read(POP_A, rdata);
    check("ovf_pop1", rdata, 16'hC121);
    bus_read(POP_A, rdata);
    check("ovf_pop2", rdata, 16'h8100);
    bus_read(POP_A, rdata);
    check("ovf_pop3", rdata, 16'h8112);
    bus_read(POP_A, rdata);
    check("ovf_pop4", rdata, 16'h8133);
    bus_read(POP_A, rdata);
    check("ovf_pop_empty", rdata, 16'h0000);

    // 6: refill with four releases, then pop on the same clk as a fifth push
    keys[0*4+0] = 1'b0; wait_frames3();
    keys[1*4+2] = 1'b0; wait_frames3();
    keys[3*4+3] = 1'b0; wait_frames3();
    keys[1*4+0] = 1'b0; wait_frames3();
    bus_read(STAT_A, rdata);
    check("full_status", rdata, 16'h0004);
    wait_col_enter(4'b1011);
    keys[2*4+1] = 1'b0;
    wait_col_enter(4'b1011);
    wait_col_enter(4'b1011);
    // Row 2 of column 1 is pushed on the third clk after column 2 is entered.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    DEVICE = POP_A;
    rd     = 1'b1;
    @(negedge clk);
    rd     = 1'b0;
    DEVICE = 16'h0000;
    check("conc_pop", DATA_out, 16'h8000);
    bus_read(STAT_A, rdata);
    check("conc_status", rdata, 16'h0004);
    bus_read(POP_A, rdata);
    check("conc_pop2", rdata, 16'h8012);
    bus_read(16'h0040, rdata);
    check("other_addr_hold", rdata, 16'h8012);
    bus_read(POP_A, rdata);
    check("conc_pop3", rdata, 16'h8033);
    bus_read(POP_A, rdata);
    check("conc_pop4", rdata, 16'h8010);
    bus_read(POP_A, rdata);
    check("conc_pop5", rdata, 16'h8021);
    bus_read(POP_A, rdata);
    check("conc_pop_empty", rdata, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
